// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: controller state encoding, register index width
// and the base opcodes that the decoder matches on.
package riscv_pkg;

    localparam int REG_W = 5;

    // Base RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } pipe_ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count enabled cycles, holding at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: turns load-use hazards, EX redirects and dmem wait
// states into per-stage enable/flush controls and the PC source select.
//
// Handshake with dmem: an access in MEM is outstanding while mem_req=1 and
// dmem_ready=0; the whole pipeline is frozen (every enable low) for those
// cycles, and the access completes in the cycle where mem_req=1 and
// dmem_ready=1. Upstream stages must hold their inputs while frozen.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_W   = riscv_pkg::REG_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    pipe_ctrl_state_e  state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze;
    logic              load_use;
    logic              active;
    logic              stall_inc;
    logic              flush_inc;

    assign freeze = mem_req & ~dmem_ready;
    assign active = (state == RUN) || (state == MEM_WAIT);

    // Load-use: a load in EX writes a non-zero register that ID is about to read
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Priority mux: freeze > redirect > load-use > normal flow
    always_comb begin
        pc_en         = 1'b0;
        pc_sel_target = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        case (state)
            BOOT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    // Pipeline held; redirect and hazard are re-evaluated next cycle
                    pc_en = 1'b0;
                end else if (ex_redirect) begin
                    pc_en         = 1'b1;
                    pc_sel_target = 1'b1;
                    if_id_en      = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_en      = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_en     = 1'b1;
                    mem_wb_en     = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, insert one bubble into EX
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    // Sequencer state, dmem wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ERR;
                    mem_err <= 1'b1;
                end
            endcase
        end
    end

    assign stall_inc = active & ~pc_en;
    assign flush_inc = active & ~freeze & ex_redirect;
    assign dbg_state = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_inc),
        .q     (flush_cnt)
    );

endmodule
